// File: rtl/udp_rx_commit_ctrl_if.sv
// Bundle of the udp_parser-side and application-side signals of udp_rx_commit_ctrl.
// The master modport is the environment side; the slave modport is the controller itself.
interface udp_rx_commit_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]      udp_data_in;
  logic            udp_byte_valid;
  logic            udp_eof;
  logic            udp_err;
  logic [7:0]      app_data_out;
  logic            app_byte_valid;
  logic            app_last;
  logic            app_ready;
  logic [ADDR_W:0] frames_pending;
  logic            overflow;
  logic [15:0]     drop_count;

  modport master (
    output udp_data_in, udp_byte_valid, udp_eof, udp_err, app_ready,
    input  app_data_out, app_byte_valid, app_last, frames_pending, overflow, drop_count
  );

  modport slave (
    input  udp_data_in, udp_byte_valid, udp_eof, udp_err, app_ready,
    output app_data_out, app_byte_valid, app_last, frames_pending, overflow, drop_count
  );
endinterface

// File: rtl/udp_rx_commit_ctrl.sv
// Frame commit/drop controller: buffers UDP payload in a circular store and releases only clean frames.
// Define UDP_RX_DROP_STATS_EN to build the saturating drop_count statistic.
module udp_rx_commit_ctrl #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst_n,
  udp_rx_commit_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d, rd_lim_q, frames_q, frames_d;
  logic            out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      out_data_q, out_data_d;
  logic [8:0]      store_mem [DEPTH];
  logic [ADDR_W+1:0] fill;
  logic            full, wr_en, commit, drop, consume, last_taken;

  // The byte parked in the output register still counts as occupied until accepted.
  assign fill       = {1'b0, wr_ptr_q - rd_ptr_q} + {{(ADDR_W+1){1'b0}}, out_vld_q};
  assign full       = (fill == (ADDR_W+2)'(DEPTH));
  assign consume    = out_vld_q & bus.app_ready;
  assign last_taken = consume & out_last_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    commit       = 1'b0;
    drop         = 1'b0;
    overflow_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.udp_byte_valid && !bus.udp_err) begin
          if (full) begin
            overflow_d = 1'b1;
            drop       = 1'b1;
            state_d    = bus.udp_eof ? S_IDLE : S_DISCARD;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (bus.udp_eof) begin
              commit       = 1'b1;
              commit_ptr_d = wr_ptr_q + 1'b1;
            end else begin
              state_d = S_RECV;
            end
          end
        end
      end
      S_RECV: begin
        if (bus.udp_byte_valid && full) begin
          wr_ptr_d   = commit_ptr_q;
          overflow_d = 1'b1;
          drop       = 1'b1;
          state_d    = (bus.udp_eof || bus.udp_err) ? S_IDLE : S_DISCARD;
        end else if (bus.udp_err || (bus.udp_eof && !bus.udp_byte_valid)) begin
          wr_ptr_d = commit_ptr_q;
          drop     = 1'b1;
          state_d  = S_IDLE;
        end else if (bus.udp_byte_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (bus.udp_eof) begin
            commit       = 1'b1;
            commit_ptr_d = wr_ptr_q + 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (bus.udp_eof || bus.udp_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_data_d = out_data_q;
    if (!out_vld_q || consume) begin
      if (rd_ptr_q != rd_lim_q) begin
        out_vld_d                = 1'b1;
        {out_last_d, out_data_d} = store_mem[rd_ptr_q[ADDR_W-1:0]];
        rd_ptr_d                 = rd_ptr_q + 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end
    frames_d = frames_q;
    if (commit && !last_taken)      frames_d = frames_q + 1'b1;
    else if (!commit && last_taken) frames_d = frames_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) store_mem[wr_ptr_q[ADDR_W-1:0]] <= {bus.udp_eof, bus.udp_data_in};
  end

  // rd_lim trails commit_ptr by a cycle, giving the two-edge eof-to-first-byte latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      rd_lim_q     <= '0;
      frames_q     <= '0;
      out_vld_q    <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_lim_q     <= commit_ptr_q;
      frames_q     <= frames_d;
      out_vld_q    <= out_vld_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef UDP_RX_DROP_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_count = drop_cnt_q;
`else
  logic drop_unused;
  assign drop_unused    = drop;
  assign bus.drop_count = '0;
`endif

  assign bus.app_data_out   = out_data_q;
  assign bus.app_byte_valid = out_vld_q;
  assign bus.app_last       = out_last_q;
  assign bus.frames_pending = frames_q;
  assign bus.overflow       = overflow_q;
endmodule

// File: doc/udp_rx_commit_ctrl.md
Name: udp_rx_commit_ctrl

Overview:
Frame commit/drop controller between udp_parser and the application. It buffers UDP payload bytes in a circular byte store and publishes a frame to the application only after udp_eof arrives cleanly. On udp_err, a bad port, or overflow, it rewinds the write pointer so no partial or bad frame leaks downstream. It also sequences committed frames out over a ready/valid byte interface.

Parameters:
DEPTH, 2048, payload store depth in bytes; must be a power of 2 and at least 16
ADDR_W, $clog2(DEPTH), store address width; pointers are ADDR_W+1 bits

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
udp_data_in  in  8  payload byte from udp_parser
udp_byte_valid  in  1  udp_data_in valid this cycle
udp_eof  in  1  final payload byte; only legal together with udp_byte_valid
udp_err  in  1  current frame is bad; may assert with or without udp_byte_valid
app_data_out  out  8  payload byte to application
app_byte_valid  out  1  app_data_out valid
app_last  out  1  app_data_out is the last byte of its frame
app_ready  in  1  application accepts the byte when app_byte_valid && app_ready
frames_pending  out  ADDR_W+1  committed frames not yet fully read
overflow  out  1  one-cycle pulse when a frame is dropped for lack of space
drop_count  out  16  saturating count of dropped frames (optional feature)

Behaviour:
- Reset values: all outputs 0; wr_ptr, commit_ptr and rd_ptr = 0; write FSM in IDLE; output register empty.
- Each store entry is 9 bits: data plus last flag. Fill level = wr_ptr - rd_ptr, in mod 2^(ADDR_W+1) arithmetic; the store is full when fill == DEPTH.
- Write FSM has three states: IDLE, RECV, DISCARD.
  - IDLE: udp_byte_valid without udp_err writes the byte, sets last = udp_eof, and goes to RECV. If udp_eof is also set, it commits in the same cycle, is counted, and stays IDLE. udp_err alone, or udp_eof without a valid byte, is ignored with no count.
  - RECV, udp_byte_valid && !udp_err: write byte at wr_ptr and increment it. If udp_eof: commit_ptr <= wr_ptr+1, frames_pending increments, go to IDLE.
  - RECV, udp_err (with or without a byte, and also when coinciding with udp_eof): wr_ptr <= commit_ptr, drop counted, go to IDLE. The errored byte is not written.
  - RECV, udp_eof without udp_byte_valid: protocol error, handled exactly as udp_err.
  - RECV, byte arrives while the store is full: byte not written, wr_ptr <= commit_ptr, overflow pulses, drop counted. If udp_eof or udp_err is present that cycle go to IDLE, else go to DISCARD.
  - DISCARD: ignore all bytes; return to IDLE on udp_eof or udp_err.
- The store has a synchronous read port with a one-entry output register.
  - A prefetch occurs when rd_ptr != commit_ptr and the output register is empty or being consumed.
  - app_byte_valid holds until accepted; app_data_out and app_last are stable while valid && !ready.
- Latency: with the store empty and app_ready high, the eof byte sampled at edge N yields the first frame byte at app_byte_valid on edge N+2. Sustained throughput is 1 byte/cycle.
- frames_pending decrements on acceptance of an app_last byte. When a commit and a last-byte acceptance occur in the same cycle, the count is unchanged.
- Read never passes commit_ptr, so uncommitted bytes are never visible to the application.
- A rewind only touches wr_ptr, so bytes already committed or being read are unaffected.
- Reset mid-frame or mid-read discards everything and returns the block to its reset state.

Optional Feature:
UDP_RX_DROP_STATS_EN:
- Defined: drop_count increments by 1 for every dropped frame (err, protocol error, overflow) and saturates at 16'hFFFF.
- Undefined: the counter logic is absent and drop_count is tied to 0. overflow is still generated.

Test Plan:
- DEPTH=64. 20-byte frame, bytes 0x00..0x13, eof on the last byte, app_ready=1 -> 20 bytes out in order; app_last only on 0x13; first byte 2 cycles after eof; frames_pending 1 then 0.
- 20-byte frame with udp_err on byte 10 -> nothing output, wr_ptr back to 0. With the feature, drop_count=1. A following 8-byte good frame is output intact.
- app_ready=0. Send three 16-byte frames -> frames_pending=3, no output. Then raise app_ready -> 48 bytes out, app_last on bytes 16, 32 and 48.
- app_ready=0, one 60-byte committed frame, then a 10-byte frame -> overflow pulses on the 5th byte, remaining bytes ignored. The 60-byte frame is intact, drop_count=1.
- Commit of a frame in the same cycle as acceptance of the previous frame's app_last -> frames_pending unchanged (1).
- rst_n low mid-read of a 20-byte frame -> app_byte_valid=0 immediately, frames_pending=0. The next frame after reset is output correctly.
